div_multicycle: RTL
===================

// Module: div_multicycle
// PURPOSE
//   Parametrised iterative integer divider for the EX stage: radix-2 restoring division, one quotient bit per cycle.
//   Adds WIDTH generalisation, early exit, an explicit divide-by-zero flag and a busy indication.
//   EX drives operands and holds start_i, then stalls the pipeline until result_ready_o.
//   result_o goes to HI/LO: HI = remainder, LO = quotient.
// PARAMETERS
//   WIDTH       32  operand width in bits (>=4); result_o is 2*WIDTH
//   EARLY_EXIT  1   1: when |dividend| < |divisor|, finish without iterating
// PORTS
//   clk             in   1         clock, rising edge
//   rst             in   1         asynchronous reset, active-high
//   signed_div_i    in   1         1 = signed (two's complement), 0 = unsigned
//   opdata1_i       in   WIDTH     dividend
//   opdata2_i       in   WIDTH     divisor
//   start_i         in   1         request; held high until the result is consumed
//   annul_i         in   1         abort the operation in progress (flush)
//   result_o        out  2*WIDTH   {remainder, quotient}
//   result_ready_o  out  1         result_o valid
//   busy_o          out  1         state != IDLE
//   div_by_zero_o   out  1         current result came from a zero divisor
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, result_o=0, result_ready_o=0, busy_o=0, div_by_zero_o=0. All outputs are registered.
//   States are IDLE, ZERO, RUN and DONE.
//   IDLE: on an edge with start_i=1 and annul_i=0, the divider latches signed_div_i, opdata1_i and opdata2_i.
//     divisor==0                            -> ZERO
//     EARLY_EXIT && |dvd|<|dvs| (magnitude) -> DONE; q=0, r=opdata1_i unchanged
//     otherwise                             -> RUN; cnt=0; magnitudes loaded
//     start_i with annul_i in the same cycle is ignored; state stays IDLE.
//   RUN: each cycle shifts {rem,quo} left by 1 and trial-subtracts the divisor magnitude from rem using a WIDTH+1-bit subtract.
//     If there is no borrow, the divider writes the difference to rem and shifts 1 into quo; otherwise it shifts 0 into quo.
//     cnt counts 0..WIDTH-1. At cnt==WIDTH-1 the state goes to DONE with sign fix-up applied.
//   Sign fix-up (signed only): quotient is negated if the operand signs differ; remainder is negated if the dividend is negative.
//     The remainder therefore takes the dividend's sign.
//     -2^(WIDTH-1) / -1 wraps: q = -2^(WIDTH-1), r = 0. No overflow flag is raised.
//   ZERO: next edge goes to DONE with result_o=0 and div_by_zero_o=1.
//   DONE: result_ready_o=1 and result_o is stable while start_i=1.
//     On an edge with start_i=0 the state goes to IDLE, and result_ready_o, result_o and div_by_zero_o clear on that edge.
//     A new start is accepted only from IDLE, so there is at least one IDLE cycle between operations.
//   Latency is counted from the edge that samples start_i (E0) to the edge that raises result_ready_o:
//     normal path WIDTH+1 edges, ZERO path 2 edges, early exit 1 edge.
//   annul_i=1 in ZERO or RUN: the next edge goes to IDLE, no result is produced, and outputs stay 0.
//     annul_i is ignored in DONE; the result stays until start_i drops.
//   Operand inputs may change after E0 without effect. start_i dropping during RUN or ZERO does not abort the operation.
//     The operation completes and then drops to IDLE on the first DONE edge that sees start_i=0.
//   Reset asserted mid-operation returns the block to the reset values immediately, with no partial result.
// TESTING (WIDTH=32 unless stated)
//   unsigned 100/7, start held -> ready exactly 33 edges after E0; result_o={32'd2,32'd14}; busy_o=1 throughout.
//   signed -7/2 -> q=32'hFFFFFFFD, r=32'hFFFFFFFF; signed 7/-2 -> q=32'hFFFFFFFD, r=32'd1.
//     Unsigned 32'hFFFFFFFF/2 -> q=32'h7FFFFFFF, r=1.
//   divisor 0 -> ready at E0+2, result_o=0, div_by_zero_o=1; drop start -> ready and flag clear next edge.
//   early exit: unsigned 5/9 -> ready at E0+1, q=0, r=5; signed -5/9 -> q=0, r=32'hFFFFFFFB.
//     With EARLY_EXIT=0, the same cases take 33 edges and give identical results.
//   annul_i pulsed in RUN cycle 10 -> IDLE next edge, ready never rises; new start 3/3 then gives q=1, r=0.
//   signed 32'h80000000/32'hFFFFFFFF -> q=32'h80000000, r=0.
//     rst asserted mid-RUN -> all outputs 0 with no clock edge.
//     WIDTH=8: unsigned 200/3 -> q=66, r=2 in 9 edges.

Source files
------------

// File: rtl/div_multicycle.sv
// Iterative radix-2 restoring divider producing {remainder, quotient}, one quotient bit per cycle.
// Supports signed/unsigned operands, early exit for small dividends, divide-by-zero flag and annul.
module div_multicycle #(
   parameter int unsigned WIDTH      = 32,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 result_ready_o,
   output logic                 busy_o,
   output logic                 div_by_zero_o
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ZERO,
      S_RUN,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic                 dvd_neg_q, dvd_neg_d;
   logic                 dvs_neg_q, dvs_neg_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 dbz_q, dbz_d;

   logic                 dvd_neg_c, dvs_neg_c;
   logic [WIDTH-1:0]     dvd_mag_c, dvs_mag_c;
   logic [WIDTH:0]       cand_c;
   logic [WIDTH+1:0]     diff_c;
   logic                 no_borrow_c;
   logic [WIDTH-1:0]     rem_next_c, quo_next_c;
   logic [WIDTH-1:0]     q_fix_c, r_fix_c;

   // Operand magnitudes for the incoming request
   always_comb begin
      dvd_neg_c = signed_div_i & opdata1_i[WIDTH-1];
      dvs_neg_c = signed_div_i & opdata2_i[WIDTH-1];
      dvd_mag_c = dvd_neg_c ? (~opdata1_i + ONE) : opdata1_i;
      dvs_mag_c = dvs_neg_c ? (~opdata2_i + ONE) : opdata2_i;
   end

   // One restoring step: shift {rem,quo} left, trial-subtract divisor magnitude
   always_comb begin
      cand_c      = {rem_q, quo_q[WIDTH-1]};
      diff_c      = {1'b0, cand_c} - {2'b00, dvs_q};
      no_borrow_c = ~diff_c[WIDTH+1];
      rem_next_c  = no_borrow_c ? WIDTH'(diff_c) : cand_c[WIDTH-1:0];
      quo_next_c  = {quo_q[WIDTH-2:0], no_borrow_c};
      q_fix_c     = (dvd_neg_q ^ dvs_neg_q) ? (~quo_next_c + ONE) : quo_next_c;
      r_fix_c     = dvd_neg_q ? (~rem_next_c + ONE) : rem_next_c;
   end

   // Next-state and output logic
   always_comb begin
      state_d   = state_q;
      dvd_neg_d = dvd_neg_q;
      dvs_neg_d = dvs_neg_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      ready_d   = ready_q;
      dbz_d     = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (start_i && !annul_i) begin
               dvd_neg_d = dvd_neg_c;
               dvs_neg_d = dvs_neg_c;
               dvs_d     = dvs_mag_c;
               if (opdata2_i == '0) begin
                  state_d = S_ZERO;
               end else if (EARLY_EXIT && (dvd_mag_c < dvs_mag_c)) begin
                  state_d  = S_DONE;
                  result_d = {opdata1_i, {WIDTH{1'b0}}};
                  ready_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = dvd_mag_c;
               end
            end
         end
         S_ZERO: begin
            if (annul_i) begin
               state_d = S_IDLE;
            end else begin
               state_d  = S_DONE;
               result_d = '0;
               ready_d  = 1'b1;
               dbz_d    = 1'b1;
            end
         end
         S_RUN: begin
            if (annul_i) begin
               state_d = S_IDLE;
            end else begin
               rem_d = rem_next_c;
               quo_d = quo_next_c;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d  = S_DONE;
                  result_d = {r_fix_c, q_fix_c};
                  ready_d  = 1'b1;
               end
            end
         end
         S_DONE: begin
            // Result held until the requester drops start; annul has no effect here
            if (!start_i) begin
               state_d  = S_IDLE;
               result_d = '0;
               ready_d  = 1'b0;
               dbz_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
         dvs_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dvd_neg_q <= dvd_neg_d;
         dvs_neg_q <= dvs_neg_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         dbz_q     <= dbz_d;
      end
   end

   assign result_o       = result_q;
   assign result_ready_o = ready_q;
   assign busy_o         = busy_q;
   assign div_by_zero_o  = dbz_q;

endmodule
